// File: rtl/ctc_pkg.sv
// Shared timing constants, instruction encodings and fetch-state type for the
// CTC instruction-fetch path.
package ctc_pkg;
  localparam int WORD_BITS = 56;
  localparam int IS_START  = 45;
  localparam int IA_START  = 19;
  localparam int INSN_W    = 10;
  localparam int ADDR_W    = 8;
  localparam int BANK_W    = 3;
  localparam int CNT_W     = $clog2(WORD_BITS);

  localparam logic [INSN_W-1:0] NOP   = 10'b0;
  localparam logic [INSN_W-1:0] CLREG = 10'b11101_010_00;

  typedef enum logic [2:0] {
    UNLOCKED,
    WAIT_IA,
    REQ,
    WAIT_ACK,
    SKIP,
    READY,
    SHIFT
  } fetch_state_t;

  function automatic logic [CNT_W-1:0] bit_at(input int t);
    return CNT_W'(t);
  endfunction
endpackage

// File: rtl/word_timer.sv
// Word-cycle bit counter: aligns to the CTC sync pulse, declares lock on a
// second correctly-timed sync rise and flags any later loss of alignment.
module word_timer
  import ctc_pkg::*;
(
  input  logic             cph2,
  input  logic             rst,
  input  logic             sync,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             locked,
  output logic             sync_err,
  output logic             realign
);
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic             sync_d_reg;
  logic             aligned_reg;
  logic             locked_reg;
  logic             rise;
  logic             at_is;

  always_comb begin
    rise     = sync & ~sync_d_reg;
    at_is    = (bit_cnt_reg == bit_at(IS_START));
    sync_err = locked_reg && ((at_is && !sync) || (rise && !at_is));
    // A rise seen while only provisionally aligned at the right bit confirms lock
    // instead of realigning.
    realign  = rise && !locked_reg && !(aligned_reg && at_is);
    if (realign)
      bit_cnt_next = bit_at(IS_START + 1);
    else if (bit_cnt_reg == bit_at(WORD_BITS - 1))
      bit_cnt_next = '0;
    else
      bit_cnt_next = bit_cnt_reg + 1'b1;
  end

  always_ff @(posedge cph2) begin
    if (rst) begin
      bit_cnt_reg <= '0;
      sync_d_reg  <= 1'b0;
      aligned_reg <= 1'b0;
      locked_reg  <= 1'b0;
    end else begin
      bit_cnt_reg <= bit_cnt_next;
      sync_d_reg  <= sync;
      if (sync_err) begin
        locked_reg  <= 1'b0;
        aligned_reg <= 1'b0;
      end else if (realign) begin
        aligned_reg <= 1'b1;
      end else if (rise && at_is && aligned_reg) begin
        locked_reg <= 1'b1;
      end
    end
  end

  assign bit_cnt = bit_cnt_reg;
  assign locked  = locked_reg;
endmodule

// File: rtl/rom_fetch_sched.sv
// Instruction-fetch scheduler: captures the serial ROM address, fetches the
// instruction over req/ack and shifts it out on `is` during the instruction field.
module rom_fetch_sched
  import ctc_pkg::*;
(
  input  logic                     cph2,
  input  logic                     rst,
  input  logic                     sync,
  input  logic                     ia,
  input  logic                     hold,
  input  logic                     bank_we,
  input  logic [BANK_W-1:0]        bank_sel,
  output logic                     rom_req,
  output logic [BANK_W+ADDR_W-1:0] rom_addr,
  input  logic                     rom_ack,
  input  logic [INSN_W-1:0]        rom_data,
  output logic                     is,
  output logic                     locked,
  output logic [ADDR_W-1:0]        cur_addr,
  output logic                     fetch_err
);
  logic [CNT_W-1:0]  bit_cnt;
  logic              sync_err;
  logic              realign;

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] addr_sr_reg, addr_sr_next;
  logic [INSN_W-1:0] insn_reg, insn_next;
  logic [INSN_W-1:0] shift_reg, shift_next;
  logic              is_reg, is_next;
  logic [ADDR_W-1:0] cur_addr_reg, cur_addr_next;
  logic              fetch_err_reg, fetch_err_next;
  logic [BANK_W-1:0] bank_reg, bank_next;
  logic [BANK_W-1:0] bank_pend_reg, bank_pend_next;
  logic              in_ia_win;
  logic              load_slot;
  logic              load_en;
  logic [INSN_W-1:0] load_src;

  word_timer u_timer (
    .cph2     (cph2),
    .rst      (rst),
    .sync     (sync),
    .bit_cnt  (bit_cnt),
    .locked   (locked),
    .sync_err (sync_err),
    .realign  (realign)
  );

  assign in_ia_win = (bit_cnt >= bit_at(IA_START)) && (bit_cnt < bit_at(IA_START + ADDR_W));
  // The shifter is loaded one bit early so `is` is registered and valid for the whole first bit.
  assign load_slot = (bit_cnt == bit_at(IS_START - 1));

  always_comb begin
    state_next     = state_reg;
    addr_sr_next   = addr_sr_reg;
    insn_next      = insn_reg;
    shift_next     = shift_reg;
    is_next        = 1'b0;
    cur_addr_next  = cur_addr_reg;
    fetch_err_next = fetch_err_reg;
    bank_pend_next = bank_we ? bank_sel : bank_pend_reg;
    bank_next      = (bit_cnt == '0) ? bank_pend_reg : bank_reg;
    load_en        = 1'b0;
    load_src       = NOP;
    case (state_reg)
      UNLOCKED: state_next = UNLOCKED;
      WAIT_IA: begin
        if (in_ia_win)
          addr_sr_next = {ia, addr_sr_reg[ADDR_W-1:1]};
        else if (bit_cnt == bit_at(IA_START + ADDR_W))
          state_next = hold ? SKIP : REQ;
      end
      REQ: state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (load_slot) begin
          load_en  = 1'b1;
          load_src = rom_ack ? rom_data : NOP;
          if (!rom_ack)
            fetch_err_next = 1'b1;
        end else if (rom_ack) begin
          insn_next  = rom_data;
          state_next = READY;
        end
      end
      SKIP: begin
        insn_next = NOP;
        if (load_slot)
          load_en = 1'b1;
        else
          state_next = READY;
      end
      READY: begin
        if (load_slot) begin
          load_en  = 1'b1;
          load_src = insn_reg;
        end
      end
      SHIFT: begin
        is_next    = shift_reg[1];
        shift_next = shift_reg >> 1;
        if (bit_cnt == bit_at(IS_START + INSN_W - 1)) begin
          is_next    = 1'b0;
          state_next = WAIT_IA;
        end
      end
      default: state_next = UNLOCKED;
    endcase

    if (load_en) begin
      insn_next     = load_src;
      shift_next    = load_src;
      is_next       = load_src[0];
      cur_addr_next = addr_sr_reg;
      state_next    = SHIFT;
    end

    if (sync_err) begin
      state_next     = UNLOCKED;
      fetch_err_next = 1'b1;
      is_next        = 1'b0;
    end else if (realign) begin
      state_next = WAIT_IA;
      is_next    = 1'b0;
    end
  end

  always_ff @(posedge cph2) begin
    if (rst) begin
      state_reg     <= UNLOCKED;
      addr_sr_reg   <= '0;
      insn_reg      <= NOP;
      shift_reg     <= '0;
      is_reg        <= 1'b0;
      cur_addr_reg  <= '0;
      fetch_err_reg <= 1'b0;
      bank_reg      <= '0;
      bank_pend_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_sr_reg   <= addr_sr_next;
      insn_reg      <= insn_next;
      shift_reg     <= shift_next;
      is_reg        <= is_next;
      cur_addr_reg  <= cur_addr_next;
      fetch_err_reg <= fetch_err_next;
      bank_reg      <= bank_next;
      bank_pend_reg <= bank_pend_next;
    end
  end

  // Address is only shifted before the request and bank only changes at bit 0,
  // so rom_addr is stable for the whole request.
  assign rom_req   = (state_reg == REQ) || (state_reg == WAIT_ACK);
  assign rom_addr  = {bank_reg, addr_sr_reg};
  assign is        = is_reg;
  assign cur_addr  = cur_addr_reg;
  assign fetch_err = fetch_err_reg;
endmodule

// File: tb/tb_rom_fetch_sched.sv
// Word-by-word bench for rom_fetch_sched: drives sync/ia/hold/bank from a
// per-word plan, models a latency-N ROM and checks fetched words via a scoreboard.
module tb_rom_fetch_sched;
  import ctc_pkg::*;

  localparam int NUM_WORDS = 13;
  localparam int RST_WORD  = 9;
  localparam int RST_BIT   = 48;
  localparam int ROM_LAT   = 3;

  logic                     cph2 = 1'b0;
  logic                     rst;
  logic                     sync;
  logic                     ia;
  logic                     hold;
  logic                     bank_we;
  logic [BANK_W-1:0]        bank_sel;
  logic                     rom_req;
  logic [BANK_W+ADDR_W-1:0] rom_addr;
  logic                     rom_ack;
  logic [INSN_W-1:0]        rom_data;
  logic                     is;
  logic                     locked;
  logic [ADDR_W-1:0]        cur_addr;
  logic                     fetch_err;

  typedef struct {
    int                word;
    logic [ADDR_W-1:0] addr;
    logic [BANK_W-1:0] bank;
    logic [INSN_W-1:0] insn;
    logic              req;
    logic              chk_is;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 cph2 = ~cph2;

  rom_fetch_sched dut (
    .cph2      (cph2),
    .rst       (rst),
    .sync      (sync),
    .ia        (ia),
    .hold      (hold),
    .bank_we   (bank_we),
    .bank_sel  (bank_sel),
    .rom_req   (rom_req),
    .rom_addr  (rom_addr),
    .rom_ack   (rom_ack),
    .rom_data  (rom_data),
    .is        (is),
    .locked    (locked),
    .cur_addr  (cur_addr),
    .fetch_err (fetch_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] word_addr(input int w);
    case (w)
      1:       return 8'h01;
      2:       return 8'h5C;
      3:       return 8'h96;
      4:       return 8'hA5;
      5:       return 8'h3C;
      6:       return 8'h81;
      7:       return 8'h42;
      9:       return 8'hC3;
      11:      return 8'h7E;
      12:      return 8'h0F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [INSN_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    if (a == 8'h01)
      return CLREG;
    return {a[1:0], a} ^ 10'h155;
  endfunction

  function automatic bit fetch_word(input int w);
    return w inside {[1:7], 9, 11, 12};
  endfunction

  function automatic bit lock_exp(input int w);
    return w inside {[1:6], 9, 11, 12};
  endfunction

  function automatic bit err_exp(input int w);
    return w inside {[3:9]};
  endfunction

  task automatic check_reset_outputs(input string phase);
    check_val({phase, "_is"},        32'(is),        32'd0);
    check_val({phase, "_rom_req"},   32'(rom_req),   32'd0);
    check_val({phase, "_rom_addr"},  32'(rom_addr),  32'd0);
    check_val({phase, "_locked"},    32'(locked),    32'd0);
    check_val({phase, "_cur_addr"},  32'(cur_addr),  32'd0);
    check_val({phase, "_fetch_err"}, 32'(fetch_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] w_addr;
    logic [BANK_W-1:0] w_bank;
    logic [INSN_W-1:0] is_bits;
    int                req_cnt;
    exp_t              e;

    rst = 1'b1; sync = 1'b0; ia = 1'b0; hold = 1'b0;
    bank_we = 1'b0; bank_sel = '0; rom_ack = 1'b0; rom_data = '0;
    req_cnt = 0; is_bits = '0; w_addr = '0; w_bank = '0;
    repeat (2) @(posedge cph2);

    for (int w = 0; w < NUM_WORDS; w++) begin
      w_addr = word_addr(w);
      w_bank = (w >= 6 && w <= 9) ? 3'd3 : 3'd0;
      for (int b = 0; b < WORD_BITS; b++) begin
        @(negedge cph2);
        // Outputs here belong to bit time b; inputs set here are sampled at the end of bit b.
        if (b == 0 && (w == 0 || w == RST_WORD + 1))
          check_reset_outputs(w == 0 ? "por" : "mid_rst");
        if (b == 0 && fetch_word(w)) begin
          e.word   = w;
          e.addr   = w_addr;
          e.bank   = w_bank;
          e.req    = (w != 4);
          e.insn   = (w == 3 || w == 4) ? NOP : rom_fn(w_addr);
          e.chk_is = (w != 7);
          sb_q.push_back(e);
        end

        rst      = (w == RST_WORD && b == RST_BIT);
        sync     = (w != 7) && (b >= IS_START) && (b < IS_START + INSN_W);
        ia       = (b >= IA_START && b < IA_START + ADDR_W) ? w_addr[b - IA_START] : 1'b0;
        hold     = (w == 4) && (b == IA_START + ADDR_W);
        bank_we  = (w == 5) && (b == 10);
        bank_sel = bank_we ? 3'd3 : 3'd0;
        if (rom_req === 1'b1) req_cnt++;
        else req_cnt = 0;
        rom_ack  = (rom_req === 1'b1) && (req_cnt == ROM_LAT + 1) && (w != 3);
        rom_data = rom_ack ? rom_fn(rom_addr[ADDR_W-1:0]) : INSN_W'($urandom);

        if (fetch_word(w) && sb_q.size() > 0) begin
          if (b == IA_START + ADDR_W && sb_q[0].req)
            check_val($sformatf("w%0d_addr_b27", w), 32'(rom_addr), 32'({sb_q[0].bank, sb_q[0].addr}));
          if (b == IA_START + ADDR_W + 1) begin
            check_val($sformatf("w%0d_req_b28", w), 32'(rom_req), 32'(sb_q[0].req));
            if (sb_q[0].req)
              check_val($sformatf("w%0d_addr_b28", w), 32'(rom_addr), 32'({sb_q[0].bank, sb_q[0].addr}));
          end
          if (b == IS_START)
            check_val($sformatf("w%0d_cur_addr", w), 32'(cur_addr), 32'(sb_q[0].addr));
        end
        if (w == 3 && b == IS_START - 1)
          check_val("w3_req_held_b44", 32'(rom_req), 32'd1);
        if (b == IS_START)
          check_val($sformatf("w%0d_req_b45", w), 32'(rom_req), 32'd0);
        if (b == IS_START + 1) begin
          check_val($sformatf("w%0d_locked", w), 32'(locked), 32'(lock_exp(w)));
          check_val($sformatf("w%0d_fetch_err", w), 32'(fetch_err), 32'(err_exp(w)));
        end
        if (b >= IS_START && b < IS_START + INSN_W)
          is_bits[b - IS_START] = is;
        if (b == IS_START - 1 || b == IS_START + INSN_W)
          check_val($sformatf("w%0d_is_idle_b%0d", w, b), 32'(is), 32'd0);
        if (b == IS_START + INSN_W - 1) begin
          if (fetch_word(w) && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.chk_is)
              check_val($sformatf("w%0d_is_word", w), 32'(is_bits), 32'(e.insn));
            else
              check_val($sformatf("w%0d_is_after_loss", w), 32'(is_bits[INSN_W-1:1]), 32'd0);
            $display("word %0d: addr 0x%02h bank %0d insn 0x%03h is 0x%03h", w, e.addr, e.bank, e.insn, is_bits);
          end else begin
            check_val($sformatf("w%0d_is_quiet", w), 32'(is_bits), 32'd0);
            $display("word %0d: no fetch, is 0x%03h", w, is_bits);
          end
        end

        if (w == RST_WORD && b == RST_BIT) begin
          sb_q.delete();
          req_cnt = 0;
          $display("word %0d: reset pulse at bit %0d", w, b);
          break;
        end
      end
    end

    @(negedge cph2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
